// File: rtl/spi_controller_if.sv
// Request-side bundle for spi_controller: valid/ready write request plus status.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;

  modport master (output req_valid, req_addr, req_data, input req_ready, busy, done);
  modport slave  (input req_valid, req_addr, req_data, output req_ready, busy, done);
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 write-frame initiator: serialises {1, addr[6:0], data[7:0]} MSB first
// with registered SCLK/COPI/nCS derived from the system clock.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             SCLK,
  output logic             COPI,
  output logic             nCS
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [15:0]   shreg, shreg_nxt;
  logic          sclk_q, sclk_nxt;
  logic          copi_q, copi_nxt;
  logic          ncs_q, ncs_nxt;
  logic          done_q, done_nxt;
  logic          half_done;
  logic [15:0]   frame;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sclk_q  <= sclk_nxt;
      copi_q  <= copi_nxt;
      ncs_q   <= ncs_nxt;
      done_q  <= done_nxt;
    end
  end

  // Every non-idle state lasts exactly one half-period; cnt restarts on each transition.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk_q;
    copi_nxt  = copi_q;
    ncs_nxt   = ncs_q;
    done_nxt  = 1'b0;
    frame     = {1'b1, bus.req_addr, bus.req_data};
    half_done = (cnt == CNT_MAX);

    if (state != IDLE) begin
      cnt_nxt = half_done ? '0 : cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          shreg_nxt = frame;
          copi_nxt  = frame[15];
          ncs_nxt   = 1'b0;
          bit_nxt   = 4'd15;
          cnt_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (half_done) begin
          sclk_nxt  = 1'b1;
          state_nxt = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (half_done) begin
          sclk_nxt = 1'b0;
          // Next bit goes out on the falling edge so it is stable a full half-period before the rise.
          if (bit_cnt != 4'd0) begin
            bit_nxt   = bit_cnt - 1'b1;
            copi_nxt  = shreg[14];
            shreg_nxt = {shreg[14:0], 1'b0};
            state_nxt = SHIFT_LO;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      SHIFT_LO: begin
        if (half_done) begin
          sclk_nxt  = 1'b1;
          state_nxt = SHIFT_HI;
        end
      end
      HOLD: begin
        if (half_done) begin
          ncs_nxt   = 1'b1;
          copi_nxt  = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (half_done) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign SCLK          = sclk_q;
  assign COPI          = copi_q;
  assign nCS           = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: three instances (CLK_DIV 1, 2, 4) share one
// SPI register-block model and one monitor, selected by sel.
module tb_spi_controller;

  typedef struct {
    logic [15:0] frame;
    int          low;
    int          done_t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  int         sel = 0;

  logic sclk0, copi0, ncs0, sclk1, copi1, ncs1, sclk2, copi2, ncs2;
  logic m_sclk, m_copi, m_ncs, m_ready, m_busy, m_done;

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  logic [7:0] regs [0:4];

  int rises = 0, done_count = 0;
  int rx_cnt = 0, low_cnt = 0, gap_cnt = 0, since_fall = 0;
  int last_low = 0, last_gap = 0, last_cnt = 0;
  logic [15:0] rx_bits = '0, last_frame = '0;
  logic p_sclk = 1'b0, p_ncs = 1'b1;

  spi_controller_if bus0 ();
  spi_controller_if bus1 ();
  spi_controller_if bus2 ();

  assign bus0.req_valid = valid && (sel == 0);
  assign bus1.req_valid = valid && (sel == 1);
  assign bus2.req_valid = valid && (sel == 2);
  assign bus0.req_addr = addr;
  assign bus1.req_addr = addr;
  assign bus2.req_addr = addr;
  assign bus0.req_data = data;
  assign bus1.req_data = data;
  assign bus2.req_data = data;

  spi_controller #(.CLK_DIV(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .SCLK(sclk0), .COPI(copi0), .nCS(ncs0));
  spi_controller #(.CLK_DIV(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .SCLK(sclk1), .COPI(copi1), .nCS(ncs1));
  spi_controller #(.CLK_DIV(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .SCLK(sclk2), .COPI(copi2), .nCS(ncs2));

  assign m_sclk  = (sel == 0) ? sclk0 : (sel == 1) ? sclk1 : sclk2;
  assign m_copi  = (sel == 0) ? copi0 : (sel == 1) ? copi1 : copi2;
  assign m_ncs   = (sel == 0) ? ncs0  : (sel == 1) ? ncs1  : ncs2;
  assign m_ready = (sel == 0) ? bus0.req_ready : (sel == 1) ? bus1.req_ready : bus2.req_ready;
  assign m_busy  = (sel == 0) ? bus0.busy : (sel == 1) ? bus1.busy : bus2.busy;
  assign m_done  = (sel == 0) ? bus0.done : (sel == 1) ? bus1.done : bus2.done;

  always #5 clk = ~clk;

  function automatic int cdOf(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Peripheral model plus scoreboard: samples on the falling clk edge, away from output updates.
  always @(negedge clk) begin
    exp_t e;
    if (m_sclk && !p_sclk) begin
      rises++;
      if (!m_ncs) begin
        rx_bits = {rx_bits[14:0], m_copi};
        rx_cnt++;
      end
    end
    if (!m_ncs) begin
      if (p_ncs) begin
        last_gap = gap_cnt;
        gap_cnt = 0;
        rx_cnt = 0;
        rx_bits = '0;
        low_cnt = 0;
        since_fall = 0;
      end else begin
        since_fall++;
      end
      low_cnt++;
    end else begin
      since_fall++;
      gap_cnt++;
      if (!p_ncs) begin
        last_low = low_cnt;
        last_frame = rx_bits;
        last_cnt = rx_cnt;
        if (rx_cnt == 16 && rx_bits[15] && rx_bits[14:8] <= 7'd4)
          regs[rx_bits[14:8]] = rx_bits[7:0];
      end
    end
    if (m_done) begin
      done_count++;
      if (q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        checkOutput("frame_bits", int'(last_frame), int'(e.frame));
        checkOutput("sclk_rises", last_cnt, 16);
        checkOutput("ncs_low_cycles", last_low, e.low);
        checkOutput("done_time", since_fall, e.done_t);
        checkOutput("ready_in_done", int'(m_ready), 1);
        checkOutput("busy_in_done", int'(m_busy), 0);
      end
    end
    p_sclk = m_sclk;
    p_ncs = m_ncs;
  end

  task automatic applyStimulus(input int d, input logic [6:0] a, input logic [7:0] v,
                               input bit hold, input bit expect_done);
    exp_t e;
    int w = 0;
    sel = d;
    addr = a;
    data = v;
    valid = 1'b1;
    while (!m_ready && w < 2000) begin
      @(negedge clk); #1;
      w++;
    end
    if (!m_ready) begin
      checkOutput("accept_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    if (expect_done) begin
      e.frame = {1'b1, a, v};
      e.low = 33 * cdOf(d);
      e.done_t = 34 * cdOf(d);
      q.push_back(e);
    end
    @(negedge clk); #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic waitIdle();
    int w = 0;
    while ((q.size() != 0 || m_busy) && w < 3000) begin
      @(negedge clk); #1;
      w++;
    end
    if (q.size() != 0 || m_busy) checkOutput("idle_timeout", 0, 1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ncs"}, int'(m_ncs), 1);
    checkOutput({tag, "_sclk"}, int'(m_sclk), 0);
    checkOutput({tag, "_copi"}, int'(m_copi), 0);
    checkOutput({tag, "_busy"}, int'(m_busy), 0);
    checkOutput({tag, "_ready"}, int'(m_ready), 1);
    checkOutput({tag, "_done"}, int'(m_done), 0);
  endtask

  initial begin
    int dc, r0, w;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      checkIdleOutputs("reset");
    end

    // CLK_DIV=2, addr 0 <- 0xA5
    applyStimulus(1, 7'd0, 8'hA5, 1'b0, 1'b1);
    waitIdle();

    // CLK_DIV=1, all-ones frame; req_* scrambled mid-frame must not matter
    applyStimulus(0, 7'h7F, 8'hFF, 1'b0, 1'b1);
    addr = 7'h00;
    data = 8'h00;
    waitIdle();

    // CLK_DIV=2, captured values survive changes on req_*
    applyStimulus(1, 7'd4, 8'h96, 1'b0, 1'b1);
    repeat (7) @(negedge clk);
    #1;
    addr = 7'd2;
    data = 8'h55;
    waitIdle();
    checkOutput("reg4_captured", int'(regs[4]), 8'h96);

    // Request pulsed while busy is ignored
    dc = done_count;
    applyStimulus(1, 7'd3, 8'h5A, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    addr = 7'd2;
    data = 8'h11;
    valid = 1'b1;
    @(negedge clk); #1;
    valid = 1'b0;
    waitIdle();
    repeat (5) @(negedge clk);
    #1;
    checkOutput("ignored_done_count", done_count - dc, 1);
    checkOutput("ignored_busy", int'(m_busy), 0);

    // Back-to-back at CLK_DIV=4 with req_valid held high
    applyStimulus(2, 7'd1, 8'h3C, 1'b1, 1'b1);
    applyStimulus(2, 7'd4, 8'hC3, 1'b0, 1'b1);
    waitIdle();
    checkOutput("b2b_ncs_gap", last_gap, 5);

    // Reset one cycle after the 5th SCLK rise aborts the frame
    r0 = rises;
    applyStimulus(2, 7'd1, 8'hFF, 1'b0, 1'b0);
    w = 0;
    while (rises - r0 < 5 && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    checkOutput("abort_rises_before_reset", rises - r0, 5);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    checkIdleOutputs("abort");
    dc = done_count;
    r0 = rises;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("abort_no_sclk", rises - r0, 0);
    checkOutput("abort_no_done", done_count - dc, 0);
    checkOutput("abort_ncs_high", int'(m_ncs), 1);

    checkOutput("reg0", int'(regs[0]), 8'hA5);
    checkOutput("reg1", int'(regs[1]), 8'h3C);
    checkOutput("reg2", int'(regs[2]), 8'h00);
    checkOutput("reg3", int'(regs[3]), 8'h5A);
    checkOutput("reg4", int'(regs[4]), 8'hC3);
    checkOutput("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI write-frame initiator for the chip's SPI register block (addresses 0-4, 8-bit data).
- Accepts one register-write request at a time over a valid/ready handshake.
- Serialises each request as a 16-bit mode-0 frame, MSB first: R/W=1, addr[6:0], data[7:0].
- Drives SCLK, COPI and nCS from the single system clock and pulses done when the frame completes.
- Used by on-chip test logic and bring-up sequencers to configure the register block without an external host.

Parameters:
- CLK_DIV, 4: system-clock cycles per SCLK half-period; legal values are 1 and above. SCLK frequency = clk/(2*CLK_DIV).

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- rst_n  input  1  reset, synchronous and active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_addr  input  7  target register address; sent unmodified, no range check
- req_data  input  8  write data
- busy  output  1  frame in progress (any state other than IDLE)
- done  output  1  one-cycle pulse when a frame completes
- SCLK  output  1  SPI clock; idles low
- COPI  output  1  serial data to the peripheral
- nCS  output  1  chip select, active-low

Behaviour:
- Reset (rst_n low at a clk edge) sets: nCS=1, SCLK=0, COPI=0, done=0, busy=0, req_ready=1, state=IDLE, counters=0.
- Reset mid-frame aborts the frame. nCS rises on that edge, no done pulse is issued, and the partial frame is discarded.
- Outputs are registered with no glitches. SCLK, COPI and nCS each change only on a clk edge.
- Shift register is 16 bits = {1'b1, req_addr, req_data}, captured at acceptance. Later changes on req_* have no effect on the frame in progress.
- Half-period counter counts 0..CLK_DIV-1, width clog2(CLK_DIV)+1. Bit counter is 4 bits, 15 down to 0.
- FSM states and transitions:
  - IDLE: req_ready=1. Acceptance happens at an edge where req_valid=1. On that edge: latch the shift register, nCS<=0, COPI<=bit15, go to SETUP.
  - SETUP: hold for CLK_DIV cycles, then SCLK<=1 and go to SHIFT_HI for bit 15.
  - SHIFT_HI: hold for CLK_DIV cycles, then SCLK<=0.
    - If bit counter >0: decrement it, COPI<=next bit on the same edge, go to SHIFT_LO.
    - Else: go to HOLD.
  - SHIFT_LO: hold for CLK_DIV cycles, then SCLK<=1 and go to SHIFT_HI.
  - HOLD: SCLK low for CLK_DIV cycles, then nCS<=1 and COPI<=0, go to GAP.
  - GAP: nCS high for CLK_DIV cycles, then done<=1 for one cycle, go to IDLE.
- COPI is stable for a full half-period before and after every SCLK rising edge. The peripheral samples on the rising edge.
- Exactly 16 SCLK rising edges occur per frame.
- Timing, with the acceptance edge at T=0:
  - nCS low from T=0 for 33*CLK_DIV cycles.
  - First SCLK rise at T=CLK_DIV.
  - done high during cycle T=34*CLK_DIV.
- req_ready=0 from the acceptance edge until the cycle done is high. req_ready is 1 in that done cycle, so back-to-back frames are possible.
- A back-to-back request accepted in the done cycle starts its frame on that edge. Minimum nCS-high time between frames is therefore CLK_DIV+1 cycles.
- req_valid asserted while req_ready=0 is ignored: no queueing, no error.
- busy=1 in every state except IDLE. busy=0 in the done cycle.

Test Plan:
- CLK_DIV=2, request addr=0 data=0xA5 -> COPI at 16 SCLK rises = 1,0000000,10100101; nCS low exactly 66 cycles; done pulse at T=68; an attached SPI register block reads addr0=0xA5.
- CLK_DIV=1, addr=7'h7F data=0xFF -> 16 ones sampled; SCLK toggles every cycle inside the frame; nCS low 33 cycles; done at T=34.
- Back-to-back requests (addr=1 data=0x3C, then addr=4 data=0xC3) with req_valid held high, CLK_DIV=4 -> second frame accepted in the done cycle; nCS high exactly 5 cycles between frames; addr1=0x3C and addr4=0xC3 in the peripheral.
- req_valid pulsed with addr=2 data=0x11 mid-frame (req_ready=0) -> ignored; exactly one frame and one done pulse observed.
- rst_n low for one cycle after the 5th SCLK rise -> next edge nCS=1, SCLK=0, COPI=0, busy=0, req_ready=1; no done pulse; no SCLK edges until a new request.
- Change req_addr/req_data during a frame -> transmitted bits match the values captured at acceptance.
